// File: rtl/mest_pro_exec_pkg.sv
// Shared types for the MESTPro execute stage.
// Opcodes, FSM states and the result flag bundle.
package mest_pro_exec_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_SHR  = 4'd5,
        OP_SHL  = 4'd6,
        OP_NOT  = 4'd7,
        OP_JMP  = 4'd8,
        OP_RET  = 4'd9,
        OP_LD   = 4'd10,
        OP_ST   = 4'd11,
        OP_MVA  = 4'd12,
        OP_HALT = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_MEM,
        S_HALTED
    } state_e;

    typedef struct packed {
        logic carry;
        logic zero;
    } flag_t;

endpackage

// File: rtl/mest_pro_exec_unit_mul_seq.sv
// Iterative shift-add multiplier, one partial product per cycle.
// done is raised combinationally in the last iteration with the final product.
module mest_pro_mul_seq #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  i_reset_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int CW = $clog2(DATA_W);

    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] mcand_q;
    logic [2*DATA_W-1:0] acc_d;
    logic [DATA_W-1:0]   mplier_q;
    logic [CW-1:0]       cnt_q;

    assign acc_d   = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign done    = busy && (cnt_q == CW'(DATA_W - 1));
    assign product = acc_d;

    // Load operands on start, then add/shift once per cycle until done.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy     <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{DATA_W{1'b0}}, op_a};
            mplier_q <= op_b;
            cnt_q    <= '0;
            busy     <= 1'b1;
        end else if (busy) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/mest_pro_exec_unit.sv
// MESTPro multi-cycle execute stage: ALU, multiply, load/store.
// MEST_EXEC_FAST_MUL_EN selects a single-cycle multiplier instead of the sequencer.
module mest_pro_exec_unit
    import mest_pro_exec_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 16,
    parameter int OPCODE_W = 4
) (
    input  logic                clk,
    input  logic                i_reset_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [OPCODE_W-1:0] i_op_code,
    input  logic [DATA_W-1:0]   i_operand1,
    input  logic [DATA_W-1:0]   i_operand2,
    output logic                o_valid,
    output logic [DATA_W-1:0]   o_result,
    output logic                o_carry,
    output logic                o_zero,
    output logic                o_jump,
    output logic                o_return_pc,
    output logic                o_end_of_code,
    output logic                o_mm_req,
    output logic                o_mm_we,
    output logic [ADDR_W-1:0]   o_mm_addr,
    output logic [DATA_W-1:0]   o_mm_wdata,
    input  logic                i_mm_ack,
    input  logic [DATA_W-1:0]   i_mm_rdata
);

    state_e              state_q;
    state_e              state_d;
    op_e                 op;
    logic                accept;
    logic                is_mem;
    logic                slow_mul;
    logic [DATA_W-1:0]   rega_q;
    logic [DATA_W:0]     wide;
    logic [DATA_W-1:0]   alu_res;
    flag_t               alu_flg;
    flag_t               flg_q;
    logic [2*DATA_W-1:0] fast_prod;
    logic [2*DATA_W-1:0] seq_prod;
    logic                mul_busy;
    logic                mul_done;

    assign op       = op_e'(i_op_code[3:0]);
    assign o_ready  = (state_q == S_IDLE);
    assign accept   = i_valid && o_ready;
    assign is_mem   = (op == OP_LD) || (op == OP_ST);
    assign o_carry  = flg_q.carry;
    assign o_zero   = flg_q.zero;

`ifdef MEST_EXEC_FAST_MUL_EN
    assign slow_mul  = 1'b0;
    assign fast_prod = {{DATA_W{1'b0}}, i_operand1}
                     * {{DATA_W{1'b0}}, i_operand2};
    assign seq_prod  = '0;
    assign mul_busy  = 1'b0;
    assign mul_done  = 1'b0;
`else
    logic mul_start;

    assign slow_mul  = (op == OP_MUL);
    assign fast_prod = '0;
    assign mul_start = accept && slow_mul;

    mest_pro_mul_seq #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .start     (mul_start),
        .op_a      (i_operand1),
        .op_b      (i_operand2),
        .busy      (mul_busy),
        .done      (mul_done),
        .product   (seq_prod)
    );
`endif

    // Single-cycle datapath; arithmetic carried at DATA_W+1 bits.
    always_comb begin
        wide    = '0;
        alu_res = '0;
        alu_flg = '0;
        case (op)
            OP_ADD: begin
                wide          = {1'b0, i_operand1} + {1'b0, i_operand2};
                alu_res       = wide[DATA_W-1:0];
                alu_flg.carry = wide[DATA_W];
            end
            OP_SUB: begin
                wide          = {1'b0, i_operand1} - {1'b0, i_operand2};
                alu_res       = wide[DATA_W-1:0];
                alu_flg.carry = wide[DATA_W];
            end
            OP_MUL: begin
                alu_res       = fast_prod[DATA_W-1:0];
                alu_flg.carry = |fast_prod[2*DATA_W-1:DATA_W];
            end
            OP_AND: alu_res = i_operand1 & i_operand2;
            OP_OR:  alu_res = i_operand1 | i_operand2;
            OP_NOT: alu_res = ~i_operand1;
            OP_SHR: begin
                alu_res       = i_operand1 >> 1;
                alu_flg.carry = i_operand1[0];
            end
            OP_SHL: begin
                alu_res       = i_operand1 << 1;
                alu_flg.carry = i_operand1[DATA_W-1];
            end
            OP_MVA: alu_res = i_operand1;
            default: ;
        endcase
        alu_flg.zero = (alu_res == '0);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // Next-state: long ops leave IDLE, HALTED is terminal.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (slow_mul)            state_d = S_MUL;
                    else if (is_mem)         state_d = S_MEM;
                    else if (op == OP_HALT)  state_d = S_HALTED;
                end
            end
            S_MUL:   if (mul_done || !mul_busy) state_d = S_IDLE;
            S_MEM:   if (i_mm_ack) state_d = S_IDLE;
            default: ;
        endcase
    end

    // Registered results, flags, control pulses and memory request.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid       <= 1'b0;
            o_result      <= '0;
            flg_q         <= '0;
            o_jump        <= 1'b0;
            o_return_pc   <= 1'b0;
            o_end_of_code <= 1'b0;
            o_mm_req      <= 1'b0;
            o_mm_we       <= 1'b0;
            o_mm_addr     <= '0;
            o_mm_wdata    <= '0;
            rega_q        <= '0;
        end else begin
            o_valid     <= 1'b0;
            o_jump      <= 1'b0;
            o_return_pc <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept && is_mem) begin
                        o_mm_req   <= 1'b1;
                        o_mm_we    <= (op == OP_ST);
                        o_mm_addr  <= {i_operand1, i_operand2};
                        o_mm_wdata <= rega_q;
                    end else if (accept && !slow_mul) begin
                        o_valid     <= 1'b1;
                        o_result    <= alu_res;
                        flg_q       <= alu_flg;
                        o_jump      <= (op == OP_JMP);
                        o_return_pc <= (op == OP_RET);
                        if (op == OP_MVA)  rega_q        <= i_operand1;
                        if (op == OP_HALT) o_end_of_code <= 1'b1;
                    end
                end
                S_MUL: begin
                    if (mul_done) begin
                        o_valid     <= 1'b1;
                        o_result    <= seq_prod[DATA_W-1:0];
                        flg_q.carry <= |seq_prod[2*DATA_W-1:DATA_W];
                        flg_q.zero  <= (seq_prod[DATA_W-1:0] == '0);
                    end
                end
                S_MEM: begin
                    if (i_mm_ack) begin
                        o_mm_req    <= 1'b0;
                        o_mm_we     <= 1'b0;
                        o_valid     <= 1'b1;
                        flg_q.carry <= 1'b0;
                        if (o_mm_we) begin
                            o_result   <= '0;
                            flg_q.zero <= 1'b1;
                        end else begin
                            o_result   <= i_mm_rdata;
                            flg_q.zero <= (i_mm_rdata == '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mest_pro_exec_unit.sv
// Randomized bench for mest_pro_exec_unit with a behavioural model.
// Honours MEST_EXEC_FAST_MUL_EN for the expected multiply latency.
module tb_mest_pro_exec_unit;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [3:0]    i_op_code = '0;
    logic [W-1:0]  i_operand1 = '0;
    logic [W-1:0]  i_operand2 = '0;
    logic          o_valid;
    logic [W-1:0]  o_result;
    logic          o_carry;
    logic          o_zero;
    logic          o_jump;
    logic          o_return_pc;
    logic          o_end_of_code;
    logic          o_mm_req;
    logic          o_mm_we;
    logic [2*W-1:0] o_mm_addr;
    logic [W-1:0]  o_mm_wdata;
    logic          i_mm_ack = 1'b0;
    logic [W-1:0]  i_mm_rdata = '0;

    always #5 clk = ~clk;

    mest_pro_exec_unit #(
        .DATA_W   (W),
        .ADDR_W   (2*W),
        .OPCODE_W (4)
    ) dut (
        .clk           (clk),
        .i_reset_n     (i_reset_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_op_code     (i_op_code),
        .i_operand1    (i_operand1),
        .i_operand2    (i_operand2),
        .o_valid       (o_valid),
        .o_result      (o_result),
        .o_carry       (o_carry),
        .o_zero        (o_zero),
        .o_jump        (o_jump),
        .o_return_pc   (o_return_pc),
        .o_end_of_code (o_end_of_code),
        .o_mm_req      (o_mm_req),
        .o_mm_we       (o_mm_we),
        .o_mm_addr     (o_mm_addr),
        .o_mm_wdata    (o_mm_wdata),
        .i_mm_ack      (i_mm_ack),
        .i_mm_rdata    (i_mm_rdata)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // model state
    int rega_m = 0;
    int mem_m [int];
    // memory responder contents
    int ram [int];

    // request observation, filled by wait_done
    int   req_cnt;
    int   req_addr;
    int   req_we;
    int   req_wd;
    bit   req_stable;
    bit   rdy_busy;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: result/carry/latency from the instruction rules.
    task automatic model_op(input int op, input int a, input int b,
                            input int dly, output int res,
                            output int c, output int lat);
        int s;
        int addr;
        res  = 0;
        c    = 0;
        lat  = 1;
        addr = a * 256 + b;
        case (op)
            0: begin s = a + b; res = s % 256; c = int'(s > 255); end
            1: begin res = (a - b + 256) % 256; c = int'(a < b); end
            2: begin
                s = a * b; res = s % 256; c = int'(s > 255);
`ifndef MEST_EXEC_FAST_MUL_EN
                lat = W + 1;
`endif
            end
            3: res = a & b;
            4: res = a | b;
            5: begin res = a / 2; c = a % 2; end
            6: begin res = (a * 2) % 256; c = int'(a >= 128); end
            7: res = 255 - a;
            10: begin
                res = mem_m.exists(addr) ? mem_m[addr] : 0;
                lat = dly + 1;
            end
            11: begin mem_m[addr] = rega_m; lat = dly + 1; end
            12: begin rega_m = a; res = a; end
            default: ;
        endcase
    endtask

    task automatic issue(input int op, input int a, input int b);
        i_valid    = 1'b1;
        i_op_code  = 4'(op);
        i_operand1 = 8'(a);
        i_operand2 = 8'(b);
        step();
        i_valid    = 1'b0;
        i_op_code  = 4'($urandom);
        i_operand1 = 8'($urandom);
        i_operand2 = 8'($urandom);
    endtask

    // Wait for o_valid, acting as memory with an ack after dly req cycles.
    task automatic wait_done(input int dly, output int lat);
        int a;
        lat        = 1;
        req_cnt    = 0;
        req_stable = 1'b1;
        rdy_busy   = 1'b0;
        while (!o_valid && lat < 60) begin
            if (o_ready) rdy_busy = 1'b1;
            if (o_mm_req) begin
                if (req_cnt == 0) begin
                    req_addr = int'(o_mm_addr);
                    req_we   = int'(o_mm_we);
                    req_wd   = int'(o_mm_wdata);
                end else if (req_addr != int'(o_mm_addr) ||
                             req_we   != int'(o_mm_we)   ||
                             req_wd   != int'(o_mm_wdata)) begin
                    req_stable = 1'b0;
                end
                req_cnt++;
                if (req_cnt == dly) begin
                    a = int'(o_mm_addr);
                    i_mm_ack = 1'b1;
                    if (o_mm_we) ram[a] = int'(o_mm_wdata);
                    i_mm_rdata = ram.exists(a) ? 8'(ram[a]) : 8'h00;
                end
            end
            step();
            i_mm_ack   = 1'b0;
            i_mm_rdata = 8'($urandom);
            lat++;
        end
    endtask

    task automatic do_op(input int op, input int a, input int b,
                         input int dly, input string tag);
        int res, c, lat, glat;
        model_op(op, a, b, dly, res, c, lat);
        issue(op, a, b);
        wait_done(dly, glat);
        chk({tag, ".done"}, int'(o_valid), 1);
        chk({tag, ".lat"}, glat, lat);
        chk({tag, ".res"}, int'(o_result), res);
        chk({tag, ".c"}, int'(o_carry), c);
        chk({tag, ".z"}, int'(o_zero), int'(res == 0));
        chk({tag, ".jmp"}, int'(o_jump), int'(op == 8));
        chk({tag, ".ret"}, int'(o_return_pc), int'(op == 9));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, ".rdy"}, int'(o_ready), 1);
        chk({tag, ".vld"}, int'(o_valid), 0);
        chk({tag, ".res"}, int'(o_result), 0);
        chk({tag, ".req"}, int'(o_mm_req), 0);
        chk({tag, ".eoc"}, int'(o_end_of_code), 0);
        chk({tag, ".c"}, int'(o_carry), 0);
    endtask

    initial begin
        int nv;
        int op;
        int a;
        int b;
        int dly;

        // reset state
        step();
        step();
        check_idle_outputs("rst");
        chk("rst.z", int'(o_zero), 0);
        i_reset_n = 1'b1;
        step();

        // reset in the middle of a multiply
        do_op(0, 5, 6, 1, "pre");
        issue(2, 8'h37, 8'h5B);
        step();
        #2 i_reset_n = 1'b0;
        #1;
        check_idle_outputs("rmul");
        rega_m = 0;
        step();
        i_reset_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (o_valid) nv++;
        end
        chk("rmul.novld", nv, 0);
        do_op(0, 1, 1, 1, "add11");

        // reset in the middle of a load drops req at once
        issue(10, 8'h40, 8'h00);
        chk("rmem.req", int'(o_mm_req), 1);
        #2 i_reset_n = 1'b0;
        #1;
        chk("rmem.req0", int'(o_mm_req), 0);
        rega_m = 0;
        step();
        i_reset_n = 1'b1;
        step();
        chk("rmem.vld", int'(o_valid), 0);

        // back-to-back ALU ops
        i_valid = 1'b1;
        i_op_code = 4'd0; i_operand1 = 8'hFF; i_operand2 = 8'h01;
        step();
        chk("b2b0.v", int'(o_valid), 1);
        chk("b2b0.r", int'(o_result), 8'h00);
        chk("b2b0.c", int'(o_carry), 1);
        chk("b2b0.z", int'(o_zero), 1);
        i_op_code = 4'd1; i_operand1 = 8'h03; i_operand2 = 8'h05;
        step();
        chk("b2b1.v", int'(o_valid), 1);
        chk("b2b1.r", int'(o_result), 8'hFE);
        chk("b2b1.c", int'(o_carry), 1);
        chk("b2b1.z", int'(o_zero), 0);
        i_op_code = 4'd5; i_operand1 = 8'h01; i_operand2 = 8'h00;
        step();
        i_valid = 1'b0;
        chk("b2b2.v", int'(o_valid), 1);
        chk("b2b2.r", int'(o_result), 8'h00);
        chk("b2b2.c", int'(o_carry), 1);
        chk("b2b2.z", int'(o_zero), 1);
        step();
        chk("b2b.pulse", int'(o_valid), 0);

        // multiply 0x10 * 0x11
        do_op(2, 8'h10, 8'h11, 1, "mul");
        chk("mul.rdylow", int'(rdy_busy), 0);

        // store then load with 3-cycle ack
        do_op(12, 8'hA5, 8'h00, 1, "mva");
        do_op(11, 8'h12, 8'h34, 3, "st");
        chk("st.reqc", req_cnt, 3);
        chk("st.addr", req_addr, 16'h1234);
        chk("st.we", req_we, 1);
        chk("st.wd", req_wd, 8'hA5);
        chk("st.stab", int'(req_stable), 1);
        chk("st.req0", int'(o_mm_req), 0);
        do_op(10, 8'h12, 8'h34, 3, "ld");
        chk("ld.reqc", req_cnt, 3);
        chk("ld.we", req_we, 0);
        chk("ld.stab", int'(req_stable), 1);

        // undefined opcode and a stray ack in IDLE
        do_op(13, 8'h5A, 8'h3C, 1, "nop");
        i_mm_ack = 1'b1;
        i_mm_rdata = 8'h77;
        step();
        i_mm_ack = 1'b0;
        chk("sack.vld", int'(o_valid), 0);
        chk("sack.rdy", int'(o_ready), 1);
        chk("sack.req", int'(o_mm_req), 0);
        do_op(0, 8'h20, 8'h22, 1, "sack.add");

        // randomized mix
        for (int i = 0; i < 300; i++) begin
            op  = int'($urandom_range(0, 14));
            a   = int'($urandom_range(0, 255));
            b   = int'($urandom_range(0, 255));
            dly = int'($urandom_range(1, 4));
            if (op == 10 || op == 11) begin
                a = 8'h12;
                b = int'($urandom_range(0, 3));
            end
            do_op(op, a, b, dly, $sformatf("r%0d.op%0d", i, op));
        end

        // control flow and halt
        do_op(8, 1, 2, 1, "jmp");
        step();
        chk("jmp.pulse", int'(o_jump), 0);
        do_op(9, 3, 4, 1, "ret");
        step();
        chk("ret.pulse", int'(o_return_pc), 0);
        issue(15, 0, 0);
        chk("halt.v", int'(o_valid), 1);
        chk("halt.eoc", int'(o_end_of_code), 1);
        chk("halt.rdy", int'(o_ready), 0);
        i_valid = 1'b1;
        i_op_code = 4'd0; i_operand1 = 8'h01; i_operand2 = 8'h01;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (o_valid) nv++;
        end
        i_valid = 1'b0;
        chk("halt.novld", nv, 0);
        chk("halt.eoc2", int'(o_end_of_code), 1);
        chk("halt.rdy2", int'(o_ready), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
